clk_emitter: RTL and testbench

Transmit-side counterpart of the recovery/lock-in path: generates a 50%-duty clock-like edge stream at a programmable half-period, measured in sys-clock cycles. Downstream recovery logic measures this same half-period and filters it against the same limit bands. Rate changes arrive through a one-entry valid/ready handshake and are applied only on phase boundaries. Pausing holds the line low between full periods.

---
 rtl/clk_emitter_pkg.sv | 20 ++
 rtl/common_pkg.sv | 9 +
 rtl/clk_emitter_rate_shadow.sv | 59 +++++
 rtl/clk_emitter.sv | 117 +++++++++++
 tb/tb_clk_emitter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_emitter_pkg.sv
// Types and widths shared by the clks_alot emitter and its rate shadow.
package clks_alot_p;

  localparam int COUNTER_WIDTH = 8;

  localparam logic [COUNTER_WIDTH-1:0] RATE_ONE = COUNTER_WIDTH'(1'b1);

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] minimum_band_minus_one;
    logic [COUNTER_WIDTH-1:0] maximum_band_minus_one;
  } half_rate_limits_s;

  typedef enum logic [1:0] {
    EMIT_IDLE   = 2'd0,
    EMIT_HIGH   = 2'd1,
    EMIT_LOW    = 2'd2,
    EMIT_PAUSED = 2'd3
  } emitter_state_e;

endpackage

// File: rtl/common_pkg.sv
// Shared clock-domain bundle: one clock plus its asynchronous active-low reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/clk_emitter_rate_shadow.sv
// One-entry valid/ready holding register for the next half-period.
// CLKS_ALOT_EMITTER_CLAMP_EN clamps captured rates into the limit band.
module rate_shadow
  import clks_alot_p::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rate_valid,
  input  logic [COUNTER_WIDTH-1:0] rate,
  input  half_rate_limits_s        half_rate_limits,
  input  logic                     consume,
  output logic                     rate_ready,
  output logic                     shadow_full,
  output logic [COUNTER_WIDTH-1:0] shadow_rate
);

  function automatic logic [COUNTER_WIDTH-1:0] fix_rate(
    input logic [COUNTER_WIDTH-1:0] raw_s,
    input half_rate_limits_s        lim_s
  );
    logic [COUNTER_WIDTH-1:0] val_s;
`ifdef CLKS_ALOT_EMITTER_CLAMP_EN
    logic [COUNTER_WIDTH-1:0] lo_s;
    logic [COUNTER_WIDTH-1:0] hi_s;
    lo_s  = lim_s.minimum_band_minus_one + RATE_ONE;
    hi_s  = lim_s.maximum_band_minus_one + RATE_ONE;
    val_s = raw_s;
    if (val_s > hi_s) val_s = hi_s;
    // Minimum applied last so it wins when the band is inverted.
    if (val_s < lo_s) val_s = lo_s;
`else
    val_s = raw_s;
`endif
    if (val_s == '0) val_s = RATE_ONE;
    return val_s;
  endfunction

`ifndef CLKS_ALOT_EMITTER_CLAMP_EN
  logic limits_unused_s;
  assign limits_unused_s = ^half_rate_limits;
`endif

  // Capture on handshake, release on phase entry; a slot only fills while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_full <= 1'b0;
      rate_ready  <= 1'b1;
      shadow_rate <= '0;
    end else if (rate_valid && rate_ready) begin
      shadow_rate <= fix_rate(rate, half_rate_limits);
      shadow_full <= 1'b1;
      rate_ready  <= 1'b0;
    end else if (consume) begin
      shadow_full <= 1'b0;
      rate_ready  <= 1'b1;
    end
  end

endmodule

// File: rtl/clk_emitter.sv
// 50%-duty edge-stream generator with programmable half-period and pause.
// Optional CLKS_ALOT_EMITTER_CLAMP_EN band-clamps new rates (in rate_shadow).
module clk_emitter
  import clks_alot_p::*;
(
  input  common_p::clk_dom_s       sys_dom_i,
  input  logic                     gen_en_i,
  input  logic                     pause_req_i,
  input  logic                     rate_valid_i,
  input  logic [COUNTER_WIDTH-1:0] rate_i,
  output logic                     rate_ready_o,
  input  half_rate_limits_s        half_rate_limits_i,
  output logic                     clk_o,
  output logic                     rise_o,
  output logic                     fall_o,
  output logic                     paused_o,
  output logic [COUNTER_WIDTH-1:0] active_rate_o
);

  logic                     clk_s;
  logic                     rst_n_s;
  emitter_state_e           state_r;
  logic [COUNTER_WIDTH-1:0] cnt_r;
  logic                     phase_end_s;
  logic                     enter_high_s;
  logic                     enter_low_s;
  logic                     to_paused_s;
  logic                     to_idle_s;
  logic                     phase_entry_s;
  logic                     shadow_full_s;
  logic [COUNTER_WIDTH-1:0] shadow_rate_s;

  assign clk_s   = sys_dom_i.clk;
  assign rst_n_s = sys_dom_i.rst_n;

  rate_shadow u_rate_shadow (
    .clk              (clk_s),
    .rst_n            (rst_n_s),
    .rate_valid       (rate_valid_i),
    .rate             (rate_i),
    .half_rate_limits (half_rate_limits_i),
    .consume          (phase_entry_s),
    .rate_ready       (rate_ready_o),
    .shadow_full      (shadow_full_s),
    .shadow_rate      (shadow_rate_s)
  );

  // Transition decode; disabling in LOW aborts the phase, in HIGH it does not.
  always_comb begin
    phase_end_s  = (cnt_r == (active_rate_o - RATE_ONE));
    enter_high_s = 1'b0;
    enter_low_s  = 1'b0;
    to_paused_s  = 1'b0;
    to_idle_s    = 1'b0;
    case (state_r)
      EMIT_IDLE: enter_high_s = gen_en_i;
      EMIT_HIGH: enter_low_s  = phase_end_s;
      EMIT_LOW: begin
        if (!gen_en_i) begin
          to_idle_s = 1'b1;
        end else if (phase_end_s) begin
          if (pause_req_i) to_paused_s  = 1'b1;
          else             enter_high_s = 1'b1;
        end else begin
          to_idle_s = 1'b0;
        end
      end
      EMIT_PAUSED: begin
        if (!gen_en_i)         to_idle_s    = 1'b1;
        else if (!pause_req_i) enter_high_s = 1'b1;
        else                   to_paused_s  = 1'b0;
      end
      default: to_idle_s = 1'b1;
    endcase
    phase_entry_s = enter_high_s | enter_low_s;
  end

  // State, phase counter, active rate and all registered line outputs.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r       <= EMIT_IDLE;
      cnt_r         <= '0;
      active_rate_o <= RATE_ONE;
      clk_o         <= 1'b0;
      rise_o        <= 1'b0;
      fall_o        <= 1'b0;
      paused_o      <= 1'b0;
    end else begin
      rise_o <= enter_high_s;
      fall_o <= enter_low_s;
      if (phase_entry_s && shadow_full_s) active_rate_o <= shadow_rate_s;
      if (enter_high_s) begin
        state_r  <= EMIT_HIGH;
        clk_o    <= 1'b1;
        paused_o <= 1'b0;
        cnt_r    <= '0;
      end else if (enter_low_s) begin
        state_r <= EMIT_LOW;
        clk_o   <= 1'b0;
        cnt_r   <= '0;
      end else if (to_paused_s) begin
        state_r  <= EMIT_PAUSED;
        clk_o    <= 1'b0;
        paused_o <= 1'b1;
        cnt_r    <= '0;
      end else if (to_idle_s) begin
        state_r  <= EMIT_IDLE;
        clk_o    <= 1'b0;
        paused_o <= 1'b0;
        cnt_r    <= '0;
      end else if ((state_r == EMIT_HIGH) || (state_r == EMIT_LOW)) begin
        cnt_r <= cnt_r + RATE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_clk_emitter.sv
// Self-checking bench for clk_emitter: phase-length model plus directed checks.
module tb_clk_emitter;
  import clks_alot_p::*;

  localparam int MIN_M1 = 3;
  localparam int MAX_M1 = 9;

  logic                     clk;
  logic                     rst_n;
  common_p::clk_dom_s       dom;
  logic                     gen_en;
  logic                     pause_req;
  logic                     rate_valid;
  logic [COUNTER_WIDTH-1:0] rate_in;
  logic                     rate_ready;
  half_rate_limits_s        lim;
  logic                     clk_line;
  logic                     rise;
  logic                     fall;
  logic                     paused;
  logic [COUNTER_WIDTH-1:0] active_rate;

  int n_cmp = 0;
  int n_bad = 0;

  assign dom = {clk, rst_n};

  clk_emitter dut (
    .sys_dom_i          (dom),
    .gen_en_i           (gen_en),
    .pause_req_i        (pause_req),
    .rate_valid_i       (rate_valid),
    .rate_i             (rate_in),
    .rate_ready_o       (rate_ready),
    .half_rate_limits_i (lim),
    .clk_o              (clk_line),
    .rise_o             (rise),
    .fall_o             (fall),
    .paused_o           (paused),
    .active_rate_o      (active_rate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Model: line level, cycles left in the phase, queue-based shadow slot.
  int m_q[$];
  int m_rate, m_left;
  bit m_run, m_paused, m_clk, m_rise, m_fall, m_ready;

  function automatic int fix(int r);
    int v = r;
`ifdef CLKS_ALOT_EMITTER_CLAMP_EN
    if (v > MAX_M1 + 1) v = MAX_M1 + 1;
    if (v < MIN_M1 + 1) v = MIN_M1 + 1;
`endif
    if (v == 0) v = 1;
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rate = 1; m_left = 0;
    m_run = 1'b0; m_paused = 1'b0; m_clk = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_ready = 1'b1;
  endtask

  task automatic model_step();
    bit take, start_hi, start_lo;
    take = rate_valid && (m_q.size() == 0);
    start_hi = 1'b0; start_lo = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0;
    if (m_paused) begin
      if (!gen_en) m_paused = 1'b0;
      else if (!pause_req) start_hi = 1'b1;
    end else if (!m_run) begin
      if (gen_en) start_hi = 1'b1;
    end else if (m_clk) begin
      m_left--;
      if (m_left == 0) start_lo = 1'b1;
    end else if (!gen_en) begin
      m_run = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (pause_req) begin m_paused = 1'b1; m_run = 1'b0; end
        else start_hi = 1'b1;
      end
    end
    if (start_hi || start_lo) begin
      if (m_q.size() > 0) m_rate = m_q.pop_front();
      m_left = m_rate; m_run = 1'b1; m_paused = 1'b0;
      m_clk = start_hi; m_rise = start_hi; m_fall = start_lo;
    end
    if (take) m_q.push_back(fix(int'(rate_in)));
    m_ready = (m_q.size() == 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("model_clk_o", int'(clk_line), int'(m_clk));
        chk("model_rise_o", int'(rise), int'(m_rise));
        chk("model_fall_o", int'(fall), int'(m_fall));
        chk("model_paused_o", int'(paused), int'(m_paused));
        chk("model_rate_ready_o", int'(rate_ready), int'(m_ready));
        chk("model_active_rate_o", int'(active_rate), m_rate);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(int r);
    rate_valid = 1'b1;
    rate_in    = COUNTER_WIDTH'(r);
    tick(1);
    rate_valid = 1'b0;
  endtask

  task automatic wait_rise_rate(int r);
    int ok = 0;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      tick(1);
      if (rise && int'(active_rate) == r) ok = 1;
    end
    chk("wait_rise_rate", ok, 1);
  endtask

  int exp_lo, exp_hi;

  initial begin
`ifdef CLKS_ALOT_EMITTER_CLAMP_EN
    exp_lo = 4; exp_hi = 10;
`else
    exp_lo = 1; exp_hi = 20;
`endif
    rst_n = 1'b0; gen_en = 1'b0; pause_req = 1'b0;
    rate_valid = 1'b0; rate_in = '0;
    lim.minimum_band_minus_one = COUNTER_WIDTH'(MIN_M1);
    lim.maximum_band_minus_one = COUNTER_WIDTH'(MAX_M1);
    tick(3);
    rst_n = 1'b1;
    chk("reset_clk_o", int'(clk_line), 0);
    chk("reset_ready", int'(rate_ready), 1);
    chk("reset_active", int'(active_rate), 1);
    chk("reset_paused", int'(paused), 0);

    // Rate 3: three cycles high, three low.
    offer(3);
    chk("ready_after_capture", int'(rate_ready), 0);
    gen_en = 1'b1;
    tick(1);
    chk("first_rise", int'(rise), 1);
    chk("first_clk_high", int'(clk_line), 1);
    chk("first_active", int'(active_rate), 3);
    tick(1);
    chk("rise_one_cycle", int'(rise), 0);
    tick(2);
    chk("fall_after_3", int'(fall), 1);
    chk("low_after_3", int'(clk_line), 0);
    tick(3);
    chk("rise_after_3_low", int'(rise), 1);

    // Zero rate becomes 1 and the line toggles every cycle.
    offer(0);
    wait_rise_rate(1);
    chk("zero_rate_active", int'(active_rate), 1);
    tick(4);

    // Mid-HIGH rate change at rate 4.
    offer(4);
    wait_rise_rate(4);
    tick(1);
    offer(2);
    chk("ready_low_after_take", int'(rate_ready), 0);
    offer(7);
    chk("high_kept_4", int'(clk_line), 1);
    chk("active_still_4", int'(active_rate), 4);
    tick(1);
    chk("fall_at_4", int'(fall), 1);
    chk("active_2_on_fall", int'(active_rate), 2);
    chk("ready_back_on_fall", int'(rate_ready), 1);
    tick(2);
    chk("rise_after_low_2", int'(rise), 1);
    chk("second_offer_dropped", int'(active_rate), 2);

    // Pause raised in HIGH: period completes, then held low.
    pause_req = 1'b1;
    tick(4);
    chk("paused_set", int'(paused), 1);
    chk("paused_low", int'(clk_line), 0);
    tick(3);
    chk("paused_held", int'(paused), 1);
    pause_req = 1'b0;
    tick(1);
    chk("resume_rise", int'(rise), 1);
    chk("resume_unpaused", int'(paused), 0);

    // Disable after one cycle of a rate-5 HIGH: no runt pulse.
    offer(5);
    wait_rise_rate(5);
    tick(1);
    gen_en = 1'b0;
    tick(3);
    chk("high_not_truncated", int'(clk_line), 1);
    tick(1);
    chk("fall_after_5", int'(fall), 1);
    tick(2);
    chk("idle_low", int'(clk_line), 0);
    tick(3);

    // Clamp band (or pass-through when the clamp is not built in).
    offer(1);
    gen_en = 1'b1;
    wait_rise_rate(exp_lo);
    chk("clamp_low_active", int'(active_rate), exp_lo);
    offer(20);
    wait_rise_rate(exp_hi);
    chk("clamp_high_active", int'(active_rate), exp_hi);

    // Asynchronous reset mid-phase.
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_o", int'(clk_line), 0);
    chk("async_rst_rise", int'(rise), 0);
    chk("async_rst_ready", int'(rate_ready), 1);
    chk("async_rst_active", int'(active_rate), 1);
    gen_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
